// File: rtl/control_sequencer_pkg.sv
// Shared constants for the 8-bit computer fetch/execute sequencer:
// opcodes, one-hot T-states and control-word bit positions.
package control_sequencer_pkg;

    localparam int OP_W     = 4;
    localparam int T_STATES = 6;
    localparam int CW_W     = 12;

    localparam logic [OP_W-1:0] OP_LDA = 4'b0000;
    localparam logic [OP_W-1:0] OP_ADD = 4'b0001;
    localparam logic [OP_W-1:0] OP_SUB = 4'b0010;
    localparam logic [OP_W-1:0] OP_OUT = 4'b1110;
    localparam logic [OP_W-1:0] OP_HLT = 4'b1111;

    localparam logic [T_STATES-1:0] T1_OH = 6'b000001;
    localparam logic [T_STATES-1:0] T2_OH = 6'b000010;
    localparam logic [T_STATES-1:0] T3_OH = 6'b000100;
    localparam logic [T_STATES-1:0] T4_OH = 6'b001000;
    localparam logic [T_STATES-1:0] T5_OH = 6'b010000;
    localparam logic [T_STATES-1:0] T6_OH = 6'b100000;

    // Control word order, MSB first: cp ep lm ce li ei la ea su eu lb lo
    localparam int CW_CP = 11;
    localparam int CW_EP = 10;
    localparam int CW_LM = 9;
    localparam int CW_CE = 8;
    localparam int CW_LI = 7;
    localparam int CW_EI = 6;
    localparam int CW_LA = 5;
    localparam int CW_EA = 4;
    localparam int CW_SU = 3;
    localparam int CW_EU = 2;
    localparam int CW_LB = 1;
    localparam int CW_LO = 0;

    function automatic logic is_mem_op(input logic [OP_W-1:0] op);
        return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer bus: slow-clock tick, run request and opcode in; T-state,
// run status and the twelve control strobes out.
interface control_sequencer_if;
    import control_sequencer_pkg::*;

    logic                tick;
    logic                run;
    logic [OP_W-1:0]     opcode;
    logic [T_STATES-1:0] t_state;
    logic                running;
    logic cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo;

    modport master (
        input  tick, run, opcode,
        output t_state, running,
        output cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo
    );

    modport slave (
        output tick, run, opcode,
        input  t_state, running,
        input  cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo
    );
endinterface

// File: rtl/control_sequencer_ring_counter6.sv
// Six-position one-hot ring counter with advance enable and a
// synchronous return-to-T1 load; async active-high reset to T1.
module ring_counter6
    import control_sequencer_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                load_t1,
    output logic [T_STATES-1:0] state
);

    logic [T_STATES-1:0] state_r;

    // One-hot ring register; load_t1 has priority over advance
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= T1_OH;
        end else if (load_t1) begin
            state_r <= T1_OH;
        end else if (en) begin
            state_r <= {state_r[T_STATES-2:0], state_r[T_STATES-1]};
        end else begin
            state_r <= state_r;
        end
    end

    assign state = state_r;

endmodule

// File: rtl/control_sequencer.sv
// Fetch/execute sequencer: T-state ring, run/halt flop and the control
// word decoded from T-state and opcode, gated by running.
module control_sequencer
    import control_sequencer_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    control_sequencer_if.master  bus
);

    logic [T_STATES-1:0] t_state_s;
    logic                running_r;
    logic                halt_s;
    logic                advance_s;
    logic [CW_W-1:0]     cw_s;
    logic [CW_W-1:0]     cw_gated_s;

    assign advance_s = bus.tick & running_r;
    assign halt_s    = advance_s & (t_state_s == T4_OH) & (bus.opcode == OP_HLT);

    // Run/halt flop: halt beats a simultaneous run request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            running_r <= 1'b0;
        end else if (halt_s) begin
            running_r <= 1'b0;
        end else if (bus.run) begin
            running_r <= 1'b1;
        end else begin
            running_r <= running_r;
        end
    end

    ring_counter6 u_ring (
        .clk     (clk),
        .reset   (reset),
        .en      (advance_s),
        .load_t1 (halt_s),
        .state   (t_state_s)
    );

    // Control word decode; opcode only matters from T4 onward
    always_comb begin
        cw_s = {CW_W{1'b0}};
        case (t_state_s)
            T1_OH: begin
                cw_s[CW_EP] = 1'b1;
                cw_s[CW_LM] = 1'b1;
            end
            T2_OH: begin
                cw_s[CW_CP] = 1'b1;
            end
            T3_OH: begin
                cw_s[CW_CE] = 1'b1;
                cw_s[CW_LI] = 1'b1;
            end
            T4_OH: begin
                if (is_mem_op(bus.opcode)) begin
                    cw_s[CW_EI] = 1'b1;
                    cw_s[CW_LM] = 1'b1;
                end else if (bus.opcode == OP_OUT) begin
                    cw_s[CW_EA] = 1'b1;
                    cw_s[CW_LO] = 1'b1;
                end else begin
                    cw_s = {CW_W{1'b0}};
                end
            end
            T5_OH: begin
                if (bus.opcode == OP_LDA) begin
                    cw_s[CW_CE] = 1'b1;
                    cw_s[CW_LA] = 1'b1;
                end else if ((bus.opcode == OP_ADD) || (bus.opcode == OP_SUB)) begin
                    cw_s[CW_CE] = 1'b1;
                    cw_s[CW_LB] = 1'b1;
                end else begin
                    cw_s = {CW_W{1'b0}};
                end
            end
            T6_OH: begin
                if ((bus.opcode == OP_ADD) || (bus.opcode == OP_SUB)) begin
                    cw_s[CW_EU] = 1'b1;
                    cw_s[CW_LA] = 1'b1;
                    cw_s[CW_SU] = (bus.opcode == OP_SUB);
                end else begin
                    cw_s = {CW_W{1'b0}};
                end
            end
            default: begin
                cw_s = {CW_W{1'b0}};
            end
        endcase
    end

    assign cw_gated_s = running_r ? cw_s : {CW_W{1'b0}};

    assign bus.t_state = t_state_s;
    assign bus.running = running_r;
    assign bus.cp = cw_gated_s[CW_CP];
    assign bus.ep = cw_gated_s[CW_EP];
    assign bus.lm = cw_gated_s[CW_LM];
    assign bus.ce = cw_gated_s[CW_CE];
    assign bus.li = cw_gated_s[CW_LI];
    assign bus.ei = cw_gated_s[CW_EI];
    assign bus.la = cw_gated_s[CW_LA];
    assign bus.ea = cw_gated_s[CW_EA];
    assign bus.su = cw_gated_s[CW_SU];
    assign bus.eu = cw_gated_s[CW_EU];
    assign bus.lb = cw_gated_s[CW_LB];
    assign bus.lo = cw_gated_s[CW_LO];

endmodule
